// File: rtl/tmu2_pkg.sv
// Shared widths and FSM state type for the TMU2 horizontal interpolator.
package tmu2_pkg;

    localparam int unsigned COORD_W = 12;
    localparam int unsigned TC_W    = 18;
    localparam int unsigned DIFF_W  = 17;
    localparam int unsigned SQW_W   = 11;
    localparam int unsigned ACC_W   = 18;

    typedef enum logic {
        StIdle = 1'b0,
        StEmit = 1'b1
    } state_e;

endpackage

// File: rtl/tmu2_hinterp_acc.sv
// One-axis texture coordinate stepper: holds t and the remainder accumulator e,
// adds q plus a carry whenever e crosses the divisor.
// Optional feature: TMU2_HINTERP_SAT_EN clamps t to the signed 18-bit range
// instead of wrapping.
module tmu2_hinterp_acc
    import tmu2_pkg::*;
(
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    input  logic                    load,
    input  logic                    step,
    input  logic signed [TC_W-1:0]  t_init,
    input  logic                    positive,
    input  logic [DIFF_W-1:0]       q,
    input  logic [DIFF_W-1:0]       r,
    input  logic [SQW_W-1:0]        divisor,
    output logic signed [TC_W-1:0]  t
);

    localparam logic signed [TC_W+1:0] WideMax = 20'sd131071;
    localparam logic signed [TC_W+1:0] WideMin = -20'sd131072;

    logic signed [TC_W-1:0] t_q, t_d;
    logic [ACC_W-1:0]       e_q, e_d;
    logic [DIFF_W-1:0]      q_q, r_q;
    logic                   pos_q;

    logic [ACC_W-1:0]       sum_e;
    logic [ACC_W-1:0]       div_ext;
    logic                   carry;
    logic [ACC_W-1:0]       inc;
    logic signed [TC_W+1:0] t_wide;
    logic signed [TC_W+1:0] inc_wide;

    // Remainder accumulate, carry compare and signed coordinate update.
    always_comb begin
        div_ext  = ACC_W'(divisor);
        sum_e    = e_q + ACC_W'(r_q);
        // r < divisor is guaranteed upstream, so one subtraction keeps e < divisor.
        carry    = (sum_e >= div_ext);
        e_d      = carry ? (sum_e - div_ext) : sum_e;
        inc      = ACC_W'(q_q) + ACC_W'(carry);
        inc_wide = signed'({2'b00, inc});
        t_wide   = pos_q ? ({{2{t_q[TC_W-1]}}, t_q} + inc_wide)
                         : ({{2{t_q[TC_W-1]}}, t_q} - inc_wide);
`ifdef TMU2_HINTERP_SAT_EN
        if (t_wide > WideMax) begin
            t_d = WideMax[TC_W-1:0];
        end else if (t_wide < WideMin) begin
            t_d = WideMin[TC_W-1:0];
        end else begin
            t_d = t_wide[TC_W-1:0];
        end
`else
        t_d = t_wide[TC_W-1:0];
`endif
    end

    // Working registers: loaded at span start, advanced on each accepted pixel.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            t_q   <= '0;
            e_q   <= '0;
            q_q   <= '0;
            r_q   <= '0;
            pos_q <= 1'b0;
        end else if (load) begin
            t_q   <= t_init;
            e_q   <= '0;
            q_q   <= q;
            r_q   <= r;
            pos_q <= positive;
        end else if (step) begin
            t_q   <= t_d;
            e_q   <= e_d;
        end
    end

    assign t = t_q;

endmodule

// File: rtl/tmu2_hinterp.sv
// TMU2 horizontal interpolator: expands one span into dst_squarew pixels with
// exact texture coordinates (Bresenham remainder stepping per axis).
// Optional feature: TMU2_HINTERP_SAT_EN (saturating tx/ty, see tmu2_hinterp_acc).
module tmu2_hinterp
    import tmu2_pkg::*;
(
    input  logic                      sys_clk,
    input  logic                      sys_rst_n,
    output logic                      busy,

    input  logic                      pipe_stb_i,
    output logic                      pipe_ack_o,
    input  logic signed [COORD_W-1:0] x,
    input  logic signed [COORD_W-1:0] y,
    input  logic signed [TC_W-1:0]    tsx,
    input  logic signed [TC_W-1:0]    tsy,
    input  logic                      diff_x_positive,
    input  logic [DIFF_W-1:0]         diff_x_q,
    input  logic [DIFF_W-1:0]         diff_x_r,
    input  logic                      diff_y_positive,
    input  logic [DIFF_W-1:0]         diff_y_q,
    input  logic [DIFF_W-1:0]         diff_y_r,
    input  logic [SQW_W-1:0]          dst_squarew,

    output logic                      pipe_stb_o,
    input  logic                      pipe_ack_i,
    output logic signed [COORD_W-1:0] dx,
    output logic signed [COORD_W-1:0] dy,
    output logic signed [TC_W-1:0]    tx,
    output logic signed [TC_W-1:0]    ty
);

    state_e                    state_q, state_d;
    logic                      load, step;
    logic [SQW_W-1:0]          cnt_q;
    logic signed [COORD_W-1:0] dx_q, dy_q;

    // State register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and span handshake; ack depends on state only.
    always_comb begin
        state_d    = state_q;
        load       = 1'b0;
        step       = 1'b0;
        pipe_ack_o = 1'b0;
        unique case (state_q)
            StIdle: begin
                pipe_ack_o = 1'b1;
                // Zero-length spans are acked and dropped.
                if (pipe_stb_i && (dst_squarew != '0)) begin
                    load    = 1'b1;
                    state_d = StEmit;
                end
            end
            StEmit: begin
                if (pipe_ack_i) begin
                    if (cnt_q == '0) begin
                        state_d = StIdle;
                    end else begin
                        step = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Destination point and remaining-pixel counter.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            dx_q  <= '0;
            dy_q  <= '0;
            cnt_q <= '0;
        end else if (load) begin
            dx_q  <= x;
            dy_q  <= y;
            cnt_q <= dst_squarew - SQW_W'(1);
        end else if (step) begin
            dx_q  <= dx_q + COORD_W'(1);
            cnt_q <= cnt_q - SQW_W'(1);
        end
    end

    tmu2_hinterp_acc u_acc_x (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .load      (load),
        .step      (step),
        .t_init    (tsx),
        .positive  (diff_x_positive),
        .q         (diff_x_q),
        .r         (diff_x_r),
        .divisor   (dst_squarew),
        .t         (tx)
    );

    tmu2_hinterp_acc u_acc_y (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .load      (load),
        .step      (step),
        .t_init    (tsy),
        .positive  (diff_y_positive),
        .q         (diff_y_q),
        .r         (diff_y_r),
        .divisor   (dst_squarew),
        .t         (ty)
    );

    assign busy       = (state_q == StEmit);
    assign pipe_stb_o = (state_q == StEmit);
    assign dx         = dx_q;
    assign dy         = dy_q;

endmodule
